// File: rtl/user_io_pio_pkg.sv
// Shared register map and bus constants for the user_io_pio block.
package user_io_pio_pkg;

    localparam int BUS_W = 32;

    localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
    localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
    localparam logic [2:0] ADDR_OUT_SET  = 3'd2;
    localparam logic [2:0] ADDR_OUT_CLR  = 3'd3;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd4;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd5;
    localparam logic [2:0] ADDR_EDGE_SEL = 3'd6;

    typedef enum logic [2:0] {
        REG_DATA_IN  = 3'd0,
        REG_DATA_OUT = 3'd1,
        REG_OUT_SET  = 3'd2,
        REG_OUT_CLR  = 3'd3,
        REG_IRQ_MASK = 3'd4,
        REG_EDGE_CAP = 3'd5,
        REG_EDGE_SEL = 3'd6,
        REG_RSVD     = 3'd7
    } reg_idx_e;

endpackage

// File: rtl/user_io_pio_debounce.sv
// Single-bit debouncer: q follows d only after DEBOUNCE_CYCLES consecutive
// differing cycles. Only present when USER_IO_PIO_DEBOUNCE_EN is defined.
`ifdef USER_IO_PIO_DEBOUNCE_EN
module pio_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // The counter never passes CNT_LAST, so it cannot wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            q   <= 1'b0;
        end else if (d == q) begin
            cnt <= '0;
        end else if (cnt >= CNT_LAST) begin
            q   <= d;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/user_io_pio.sv
// Avalon-MM PIO with synchronised/debounced inputs, edge capture, level IRQ
// and set/clear outputs. Debounce is enabled by defining USER_IO_PIO_DEBOUNCE_EN.
module user_io_pio
    import user_io_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] INPUT_INVERT    = '0,
    parameter logic [WIDTH-1:0] OUT_RESET       = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [BUS_W-1:0]  avs_writedata,
    output logic [BUS_W-1:0]  avs_readdata,
    output logic              avs_readdatavalid,
    input  logic [WIDTH-1:0]  pio_in,
    output logic [WIDTH-1:0]  pio_out,
    output logic              irq
);

    logic [WIDTH-1:0] sync1, sync2, s;
    logic [WIDTH-1:0] stable, stable_d;
    logic [WIDTH-1:0] edge_cap, irq_mask, edge_sel;
    logic [WIDTH-1:0] wdata, new_edges, ec_clr;
    logic [BUS_W-1:0] rd_mux;
    logic             unused_wdata;

    assign wdata        = avs_writedata[WIDTH-1:0];
    assign unused_wdata = ^avs_writedata;
    assign s            = sync2 ^ INPUT_INVERT;

`ifdef USER_IO_PIO_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        pio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .reset (reset),
            .d     (s[i]),
            .q     (stable[i])
        );
    end
`else
    assign stable = s;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            stable_d <= '0;
        end else begin
            sync1    <= pio_in;
            sync2    <= sync1;
            stable_d <= stable;
        end
    end

    // Per-bit edge polarity: 0 captures rising, 1 captures falling.
    assign new_edges = (stable & ~stable_d & ~edge_sel) | (~stable & stable_d & edge_sel);
    assign ec_clr    = (avs_write && avs_address == ADDR_EDGE_CAP) ? wdata : '0;

    always_comb begin
        rd_mux = '0;
        case (reg_idx_e'(avs_address))
            REG_DATA_IN:  rd_mux[WIDTH-1:0] = stable;
            REG_DATA_OUT: rd_mux[WIDTH-1:0] = pio_out;
            REG_IRQ_MASK: rd_mux[WIDTH-1:0] = irq_mask;
            REG_EDGE_CAP: rd_mux[WIDTH-1:0] = edge_cap;
            REG_EDGE_SEL: rd_mux[WIDTH-1:0] = edge_sel;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pio_out           <= OUT_RESET;
            irq_mask          <= '0;
            edge_sel          <= '0;
            edge_cap          <= '0;
            irq               <= 1'b0;
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            if (avs_write) begin
                case (reg_idx_e'(avs_address))
                    REG_DATA_OUT: pio_out  <= wdata;
                    REG_OUT_SET:  pio_out  <= pio_out | wdata;
                    REG_OUT_CLR:  pio_out  <= pio_out & ~wdata;
                    REG_IRQ_MASK: irq_mask <= wdata;
                    REG_EDGE_SEL: edge_sel <= wdata;
                    default: ;
                endcase
            end
            // A new edge wins over a same-cycle write-1-to-clear.
            edge_cap          <= (edge_cap & ~ec_clr) | new_edges;
            irq               <= |(edge_cap & irq_mask);
            avs_readdatavalid <= avs_read;
            if (avs_read) begin
                avs_readdata <= rd_mux;
            end
        end
    end

endmodule

// File: doc/user_io_pio.md
Name: user_io_pio

Overview:
- Parametrised Avalon-MM PIO that replaces the fixed 4-bit LED, DIP-switch and push-button PIOs in the platform system.
- Provides WIDTH input channels with synchroniser, debounce, optional inversion, per-bit edge capture, interrupt mask and a level IRQ.
- Provides WIDTH output channels with atomic set/clear writes.
- Instantiated once per user-I/O group on the system clock domain.

Parameters:
- WIDTH, 4, number of input and output channels (1..32).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed before a debounced input changes (>=2).
- INPUT_INVERT, 0, WIDTH-bit mask; a 1 inverts that input after synchronisation (for active-low push buttons).
- OUT_RESET, 0, WIDTH-bit reset value of the output register.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- avs_address  in  3  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, valid one cycle after avs_read.
- avs_readdatavalid  out  1  qualifies avs_readdata.
- pio_in  in  WIDTH  raw asynchronous inputs.
- pio_out  out  WIDTH  output register.
- irq  out  1  level interrupt.

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-high, named reset.
- Reset values:
  - pio_out = OUT_RESET.
  - Synchroniser flops, debounced state, edge_cap, irq_mask, edge_sel = 0.
  - avs_readdata = 0, avs_readdatavalid = 0, irq = 0.
  - Debounce counters = 0.
- Input path:
  - 2-FF synchroniser per bit, then XOR with INPUT_INVERT, giving s.
  - Per-bit debounce: if s equals stable, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, stable takes s and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
  - Counter width is $clog2(DEBOUNCE_CYCLES). It saturates and never wraps.
- Edge detect: compare stable against stable_d (one-cycle delayed).
  - edge_sel bit = 0: a rising edge (0->1) sets edge_cap[i].
  - edge_sel bit = 1: a falling edge (1->0) sets edge_cap[i].
  - edge_cap is set the cycle after stable changes.
- Register map (word address); bits above WIDTH read 0 and ignore writes:
  - 0 DATA_IN: read-only, returns stable.
  - 1 DATA_OUT: read/write.
  - 2 OUT_SET: write-only; pio_out |= wdata. Reads 0.
  - 3 OUT_CLR: write-only; pio_out &= ~wdata. Reads 0.
  - 4 IRQ_MASK: read/write.
  - 5 EDGE_CAP: read; write-1-to-clear.
  - 6 EDGE_SEL: read/write.
  - 7: reads 0, writes ignored.
- Bus timing:
  - Reads have fixed latency 1: avs_readdatavalid pulses the cycle after avs_read.
  - Writes take effect on the clock edge where avs_write=1.
  - avs_read and avs_write asserted together: the write is performed and the read returns the pre-write value.
- Simultaneous events:
  - EDGE_CAP W1C in the same cycle a new edge sets the same bit: set wins, bit stays 1.
  - OUT_SET and OUT_CLR cannot coincide (single port).
  - Writing EDGE_SEL does not itself create an edge.
- irq is registered: irq <= |(edge_cap & irq_mask). It asserts one cycle after edge_cap or irq_mask makes the term true.
- Reset mid-debounce discards the partial count. Stable returns to 0, so an input held high after reset produces a rising edge once debounced.

Optional Feature:
- Macro USER_IO_PIO_DEBOUNCE_EN.
- Defined: debounce as described above.
- Undefined: debounce logic is removed and stable = s directly. Latency is 2 synchroniser cycles and glitches pass through. DEBOUNCE_CYCLES is ignored.

Decomposition:
- Package user_io_pio_pkg holds:
  - Register address localparams: ADDR_DATA_IN=0 … ADDR_EDGE_SEL=6.
  - A register-index enum typedef.
  - The 32-bit bus width constant.
- Sub-module pio_debounce: single bit, parameter DEBOUNCE_CYCLES, ports clk, reset, d, q. Instantiated WIDTH times in a generate loop.
- Synchroniser, edge logic and the register file stay in the top module.

Test Plan (bench WIDTH=4, DEBOUNCE_CYCLES=4, INPUT_INVERT=4'b0000):
1. Release reset with pio_in=4'b0000 -> pio_out=OUT_RESET, irq=0, read addr0 returns 0 with avs_readdatavalid one cycle after avs_read.
2. Drive pio_in[0]=1 and hold -> DATA_IN bit0 reads 1 after 2+4 cycles. With IRQ_MASK=1, EDGE_CAP=1 and irq=1 one cycle after edge_cap sets. Write 1 to addr5 -> EDGE_CAP=0, irq=0 next cycle.
3. Pulse pio_in[1] high for 3 cycles -> DATA_IN, EDGE_CAP and irq unchanged. With macro undefined, the same pulse sets DATA_IN bit1 after 2 cycles.
4. Set EDGE_SEL=4'b0100, raise then lower pio_in[2] -> EDGE_CAP bit2 sets only on the fall.
5. Write DATA_OUT=4'b1010, OUT_SET=4'b0001, OUT_CLR=4'b1000 -> pio_out=4'b1010, 4'b1011, then 4'b0011. Read addr1 returns 0x3.
6. W1C on addr5 in the same cycle a new edge sets bit3 -> bit3 remains 1. Assert reset mid-debounce -> all outputs at reset values immediately, asynchronously.
